// File: rtl/sound_mailbox_fifo.sv
// Bidirectional 68k <-> 6502 sound mailbox: command and response FIFOs with NMI/host interrupt.
// Define SOUND_MAILBOX_FWFT_EN for first-word fall-through read data; default is a registered read.
module sound_mailbox_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned NMI_CYCLES = 16
) (
    input  logic                       clk100,
    input  logic                       rst,
    input  logic                       snd_rst,
    input  logic                       host_wr,
    input  logic [DATA_W-1:0]          host_din,
    input  logic                       host_rd,
    output logic [DATA_W-1:0]          host_dout,
    input  logic                       snd_wr,
    input  logic [DATA_W-1:0]          snd_din,
    input  logic                       snd_rd,
    output logic [DATA_W-1:0]          snd_dout,
    output logic [$clog2(DEPTH):0]     cmd_count,
    output logic [$clog2(DEPTH):0]     rsp_count,
    output logic                       ctrl_sndbuf,
    output logic                       ctrl_68kbuf,
    output logic                       cmd_full,
    output logic                       rsp_full,
    output logic                       cmd_ovf,
    output logic                       rsp_ovf,
    input  logic                       ovf_clr,
    output logic                       snd_nmi_b,
    output logic                       host_int_b
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned NW = $clog2(NMI_CYCLES + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_W-1:0] cmd_mem [DEPTH];
    logic [DATA_W-1:0] rsp_mem [DEPTH];
    logic [PW-1:0]     cmd_wp, cmd_rp, rsp_wp, rsp_rp;
    logic [NW-1:0]     nmi_cnt;
    logic              cmd_push, cmd_pop, cmd_drop;
    logic              rsp_push, rsp_pop, rsp_drop;

    // A pop on a full FIFO always succeeds, so a same-cycle push can take its slot.
    assign cmd_pop  = snd_rd && (cmd_count != '0);
    assign cmd_push = host_wr && (!cmd_full || snd_rd);
    assign cmd_drop = host_wr && cmd_full && !snd_rd;
    assign rsp_pop  = host_rd && (rsp_count != '0);
    assign rsp_push = snd_wr && (!rsp_full || host_rd);
    assign rsp_drop = snd_wr && rsp_full && !host_rd;

    assign cmd_full    = (cmd_count == FULL_CNT);
    assign rsp_full    = (rsp_count == FULL_CNT);
    assign ctrl_sndbuf = (cmd_count != '0);
    assign ctrl_68kbuf = (rsp_count != '0);
    assign host_int_b  = ~ctrl_68kbuf;
    assign snd_nmi_b   = (nmi_cnt == '0);

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            cmd_wp    <= '0;
            cmd_rp    <= '0;
            cmd_count <= '0;
            rsp_wp    <= '0;
            rsp_rp    <= '0;
            rsp_count <= '0;
            cmd_ovf   <= 1'b0;
            rsp_ovf   <= 1'b0;
            nmi_cnt   <= '0;
        end else begin
            // Clear first so a same-cycle overflow wins.
            if (ovf_clr) begin
                cmd_ovf <= 1'b0;
                rsp_ovf <= 1'b0;
            end
            if (cmd_drop && !snd_rst) cmd_ovf <= 1'b1;
            if (rsp_drop && !snd_rst) rsp_ovf <= 1'b1;

            if (snd_rst) begin
                cmd_wp    <= '0;
                cmd_rp    <= '0;
                cmd_count <= '0;
                rsp_wp    <= '0;
                rsp_rp    <= '0;
                rsp_count <= '0;
                nmi_cnt   <= '0;
            end else begin
                if (cmd_push) cmd_wp <= cmd_wp + PW'(1);
                if (cmd_pop)  cmd_rp <= cmd_rp + PW'(1);
                if (cmd_push && !cmd_pop)      cmd_count <= cmd_count + CW'(1);
                else if (!cmd_push && cmd_pop) cmd_count <= cmd_count - CW'(1);

                if (rsp_push) rsp_wp <= rsp_wp + PW'(1);
                if (rsp_pop)  rsp_rp <= rsp_rp + PW'(1);
                if (rsp_push && !rsp_pop)      rsp_count <= rsp_count + CW'(1);
                else if (!rsp_push && rsp_pop) rsp_count <= rsp_count - CW'(1);

                if (cmd_push)            nmi_cnt <= NW'(NMI_CYCLES);
                else if (nmi_cnt != '0)  nmi_cnt <= nmi_cnt - NW'(1);
            end
        end
    end

    always_ff @(posedge clk100) begin
        if (cmd_push && !snd_rst) cmd_mem[cmd_wp] <= host_din;
        if (rsp_push && !snd_rst) rsp_mem[rsp_wp] <= snd_din;
    end

`ifdef SOUND_MAILBOX_FWFT_EN
    always_comb begin
        snd_dout  = '0;
        host_dout = '0;
        if (cmd_count != '0) snd_dout  = cmd_mem[cmd_rp];
        if (rsp_count != '0) host_dout = rsp_mem[rsp_rp];
    end
`else
    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            snd_dout  <= '0;
            host_dout <= '0;
        end else begin
            if (cmd_pop && !snd_rst) snd_dout  <= cmd_mem[cmd_rp];
            if (rsp_pop && !snd_rst) host_dout <= rsp_mem[rsp_rp];
        end
    end
`endif

endmodule

// File: tb/tb_sound_mailbox_fifo.sv
// Scoreboard bench for sound_mailbox_fifo: queue-based reference model, per-cycle expectations
// checked by an independent monitor. Honours SOUND_MAILBOX_FWFT_EN for the read-data model.
module tb_sound_mailbox_fifo;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned NMI    = 16;

    logic       clk100 = 1'b0;
    logic       rst = 1'b1;
    logic       snd_rst = 1'b0, host_wr = 1'b0, host_rd = 1'b0, snd_wr = 1'b0, snd_rd = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [7:0] host_din = '0, snd_din = '0;
    logic [7:0] host_dout, snd_dout;
    logic [2:0] cmd_count, rsp_count;
    logic       ctrl_sndbuf, ctrl_68kbuf, cmd_full, rsp_full, cmd_ovf, rsp_ovf;
    logic       snd_nmi_b, host_int_b;

    sound_mailbox_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NMI_CYCLES(NMI)) dut (
        .clk100(clk100), .rst(rst), .snd_rst(snd_rst),
        .host_wr(host_wr), .host_din(host_din), .host_rd(host_rd), .host_dout(host_dout),
        .snd_wr(snd_wr), .snd_din(snd_din), .snd_rd(snd_rd), .snd_dout(snd_dout),
        .cmd_count(cmd_count), .rsp_count(rsp_count),
        .ctrl_sndbuf(ctrl_sndbuf), .ctrl_68kbuf(ctrl_68kbuf),
        .cmd_full(cmd_full), .rsp_full(rsp_full), .cmd_ovf(cmd_ovf), .rsp_ovf(rsp_ovf),
        .ovf_clr(ovf_clr), .snd_nmi_b(snd_nmi_b), .host_int_b(host_int_b)
    );

    always #5 clk100 = ~clk100;

    typedef struct {
        logic [7:0] snd_dout, host_dout;
        int         cmd_cnt, rsp_cnt;
        bit         cmd_ovf, rsp_ovf, nmi_b;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;

    logic [7:0] cq[$], rq[$];
    int         nmi_left = 0;
    bit         m_cmd_ovf = 0, m_rsp_ovf = 0;
    logic [7:0] m_snd_dout = '0, m_host_dout = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model advances by the spec's rules and queues what must follow.
    task automatic cycle(input bit hw, input logic [7:0] hd, input bit hr,
                         input bit sw, input logic [7:0] sd, input bit sr,
                         input bit srst, input bit clr);
        bit   cpush, cpop, rpush, rpop;
        exp_t e;
        @(posedge clk100); #1;
        host_wr = hw; host_din = hd; host_rd = hr;
        snd_wr = sw; snd_din = sd; snd_rd = sr;
        snd_rst = srst; ovf_clr = clr;
        if (clr) begin m_cmd_ovf = 0; m_rsp_ovf = 0; end
        if (srst) begin
            cq.delete(); rq.delete(); nmi_left = 0;
        end else begin
            cpop  = sr && cq.size() > 0;
            cpush = hw && (cq.size() < DEPTH || sr);
            rpop  = hr && rq.size() > 0;
            rpush = sw && (rq.size() < DEPTH || hr);
            if (hw && !cpush) m_cmd_ovf = 1;
            if (sw && !rpush) m_rsp_ovf = 1;
            if (cpop) m_snd_dout = cq.pop_front();
            if (rpop) m_host_dout = rq.pop_front();
            if (cpush) cq.push_back(hd);
            if (rpush) rq.push_back(sd);
            if (cpush) nmi_left = NMI;
            else if (nmi_left > 0) nmi_left--;
        end
`ifdef SOUND_MAILBOX_FWFT_EN
        m_snd_dout  = (cq.size() > 0) ? cq[0] : 8'h00;
        m_host_dout = (rq.size() > 0) ? rq[0] : 8'h00;
`endif
        e.snd_dout = m_snd_dout; e.host_dout = m_host_dout;
        e.cmd_cnt = cq.size(); e.rsp_cnt = rq.size();
        e.cmd_ovf = m_cmd_ovf; e.rsp_ovf = m_rsp_ovf;
        e.nmi_b = (nmi_left == 0);
        exp_q.push_back(e);
    endtask

    task automatic idle(); cycle(0, 8'h00, 0, 0, 8'h00, 0, 0, 0); endtask
    task automatic cpush(input logic [7:0] d); cycle(1, d, 0, 0, 8'h00, 0, 0, 0); endtask
    task automatic cpopt(); cycle(0, 8'h00, 0, 0, 8'h00, 1, 0, 0); endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_cmd_count"}, 32'(cmd_count), 0);
        chk({tag, "_rsp_count"}, 32'(rsp_count), 0);
        chk({tag, "_snd_dout"},  32'(snd_dout), 0);
        chk({tag, "_host_dout"}, 32'(host_dout), 0);
        chk({tag, "_flags"}, 32'({ctrl_sndbuf, ctrl_68kbuf, cmd_full, rsp_full, cmd_ovf, rsp_ovf}), 0);
        chk({tag, "_nmi_b"}, 32'(snd_nmi_b), 1);
        chk({tag, "_int_b"}, 32'(host_int_b), 1);
    endtask

    // Monitor: each edge that consumed stimulus is checked half a cycle later.
    initial begin
        exp_t cur;
        bit   have;
        forever begin
            @(posedge clk100);
            have = 0;
            if (exp_q.size() > 0) begin cur = exp_q.pop_front(); have = 1; end
            @(negedge clk100);
            if (have) begin
                chk("cmd_count",  32'(cmd_count), 32'(cur.cmd_cnt));
                chk("rsp_count",  32'(rsp_count), 32'(cur.rsp_cnt));
                chk("snd_dout",   32'(snd_dout), 32'(cur.snd_dout));
                chk("host_dout",  32'(host_dout), 32'(cur.host_dout));
                chk("cmd_full",   32'(cmd_full), 32'(cur.cmd_cnt == DEPTH));
                chk("rsp_full",   32'(rsp_full), 32'(cur.rsp_cnt == DEPTH));
                chk("ctrl_sndbuf", 32'(ctrl_sndbuf), 32'(cur.cmd_cnt != 0));
                chk("ctrl_68kbuf", 32'(ctrl_68kbuf), 32'(cur.rsp_cnt != 0));
                chk("host_int_b", 32'(host_int_b), 32'(cur.rsp_cnt == 0));
                chk("cmd_ovf",    32'(cmd_ovf), 32'(cur.cmd_ovf));
                chk("rsp_ovf",    32'(rsp_ovf), 32'(cur.rsp_ovf));
                chk("snd_nmi_b",  32'(snd_nmi_b), 32'(cur.nmi_b));
            end
        end
    end

    initial begin
        #2;
        check_reset_values("reset");
        @(negedge clk100); @(negedge clk100);
        rst = 1'b0;

        // Fill command FIFO, overflow, drain in order, clear overflow.
        cpush(8'h11); cpush(8'h22); cpush(8'h33); cpush(8'h44);
        cpush(8'h55);
        idle(); idle();
        repeat (4) cpopt();
        cycle(0, 8'h00, 0, 0, 8'h00, 0, 0, 1);
        // Response path and host interrupt.
        cycle(0, 8'h00, 0, 1, 8'hA5, 0, 0, 0);
        idle();
        cycle(0, 8'h00, 1, 0, 8'h00, 0, 0, 0);
        idle();
        // Simultaneous push/pop on full, then on empty.
        cpush(8'h71); cpush(8'h72); cpush(8'h73); cpush(8'h74);
        cycle(1, 8'h66, 0, 0, 8'h00, 1, 0, 0);
        repeat (4) cpopt();
        cycle(1, 8'h77, 0, 0, 8'h00, 1, 0, 0);
        cpopt();
        cpopt(); cpopt();
        cycle(0, 8'h00, 1, 0, 8'h00, 0, 0, 0);
        // snd_rst with 3 entries queued, NMI active and overflow flagged.
        cpush(8'h01); cpush(8'h02); cpush(8'h03); cpush(8'h04); cpush(8'h05);
        cpopt();
        cycle(0, 8'h00, 0, 1, 8'h99, 0, 0, 0);
        cycle(0, 8'h00, 0, 0, 8'h00, 0, 1, 0);
        repeat (3) idle();

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(99) < 45, 8'($urandom_range(255)),
                  $urandom_range(99) < 35,
                  $urandom_range(99) < 40, 8'($urandom_range(255)),
                  $urandom_range(99) < 35,
                  $urandom_range(99) < 2,
                  $urandom_range(99) < 5);
        end

        // Asynchronous reset between edges with traffic in flight.
        cycle(1, 8'hC1, 0, 1, 8'hD1, 0, 0, 0);
        cycle(1, 8'hC2, 0, 1, 8'hD2, 0, 0, 0);
        @(posedge clk100); #6;
        rst = 1'b1;
        host_wr = 0; host_rd = 0; snd_wr = 0; snd_rd = 0; snd_rst = 0; ovf_clr = 0;
        #1;
        check_reset_values("async_rst");
        @(posedge clk100); @(negedge clk100);
        rst = 1'b0;
        cq.delete(); rq.delete(); nmi_left = 0;
        m_cmd_ovf = 0; m_rsp_ovf = 0; m_snd_dout = '0; m_host_dout = '0;
        cpush(8'hE7); cpopt(); idle();

        for (int n = 0; n < 50 && exp_q.size() > 0; n++) @(negedge clk100);
        @(negedge clk100); #1;
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sound_mailbox_fifo.md
# sound_mailbox_fifo

Parametrised, bidirectional mailbox between the 68k host and the 6502 sound CPU, replacing the single-byte SNDBUF/68KBUF latch pair. Two independent FIFOs: a command FIFO carries host-to-sound bytes and a response FIFO carries sound-to-host bytes. The block drives the sound NMI and host interrupt from FIFO state. It sits between the host address decode and io_sound in the clk100 domain.

## Interface
- DATA_W, 8: width of each FIFO entry.
- DEPTH, 4: entries per FIFO; power of two, ≥2.
- NMI_CYCLES, 16: sound NMI low-pulse length in clk100 cycles; ≥1.
- clk100  in  1  system clock; all logic rises on posedge.
- rst  in  1  asynchronous active-high reset.
- snd_rst  in  1  synchronous flush of both FIFOs; sound CPU reset.
- host_wr  in  1  one-cycle strobe; push host_din into the command FIFO.
- host_din  in  DATA_W  command byte.
- host_rd  in  1  one-cycle strobe; pop the response FIFO.
- host_dout  out  DATA_W  response data.
- snd_wr  in  1  one-cycle strobe; push snd_din into the response FIFO.
- snd_din  in  DATA_W  response byte.
- snd_rd  in  1  one-cycle strobe; pop the command FIFO.
- snd_dout  out  DATA_W  command data.
- cmd_count  out  $clog2(DEPTH)+1  command FIFO occupancy.
- rsp_count  out  $clog2(DEPTH)+1  response FIFO occupancy.
- ctrl_sndbuf  out  1  command FIFO non-empty.
- ctrl_68kbuf  out  1  response FIFO non-empty.
- cmd_full, rsp_full  out  1  FIFO full.
- cmd_ovf, rsp_ovf  out  1  sticky overflow flags.
- ovf_clr  in  1  clears both sticky overflow flags.
- snd_nmi_b  out  1  active-low NMI to the 6502.
- host_int_b  out  1  active-low interrupt to the 68k.

## Operation
- Each FIFO is a circular buffer with a write pointer, a read pointer, and a count. Pointers are $clog2(DEPTH) bits wide and wrap naturally.
- Push: accepted when not full, or when full with a simultaneous pop. If the FIFO is full and no pop occurs, the byte is dropped, the count is unchanged, and the ovf flag is set.
- Pop: accepted when count > 0. A pop on an empty FIFO is ignored with no flag, and the pointers and dout are unchanged.
- Simultaneous push and pop:
  - Non-empty FIFO: both are accepted and the count is unchanged.
  - Empty FIFO: only the push is accepted.
- ovf flags stay set until ovf_clr or rst. If ovf_clr and a new overflow occur in the same cycle, the flag stays set.
- snd_rst:
  - Zeroes both FIFOs' pointers and counts, and clears the NMI counter.
  - Leaves the ovf flags unchanged.
  - Overrides any same-cycle push or pop.
- NMI: each accepted command push loads the counter with NMI_CYCLES. snd_nmi_b = 0 while the counter is non-zero, and the counter decrements each cycle. A push during an active pulse reloads the counter, extending the pulse rather than producing a second edge.
- host_int_b = ~ctrl_68kbuf (level-sensitive).
- ctrl_sndbuf = (cmd_count != 0); ctrl_68kbuf = (rsp_count != 0); full = (count == DEPTH).

## Timing
- Reset values (rst):
  - counts 0, pointers 0, dout 0, ovf 0.
  - snd_nmi_b 1, host_int_b 1.
  - ctrl_* 0, full 0.
- Push on cycle N: count, flags, and host_int_b update at N+1; snd_nmi_b goes low at N+1.
- Pop, default mode: dout is registered and loads the head entry at N+1. The count decrements at N+1.
- Pop, FWFT mode: see Configuration.
- All flags are registered or derived from registered counts. There are no combinational paths from strobes to outputs.
- rst mid-pulse: snd_nmi_b returns to 1 immediately, asynchronously.

## Configuration
- SOUND_MAILBOX_FWFT_EN defined: first-word fall-through.
  - dout combinationally shows mem[rd_ptr] whenever count > 0, so the head entry is visible one cycle after the push that filled an empty FIFO.
  - A pop advances to the next entry at N+1.
  - dout = 0 when empty.
- SOUND_MAILBOX_FWFT_EN undefined: registered read with 1-cycle latency after each pop; dout holds its last value otherwise.

## Test plan
- Reset, then push host bytes 0x11, 0x22, 0x33, 0x44 (DEPTH=4) → cmd_full=1, cmd_count=4. snd_nmi_b low for 16 cycles after the first push, with the pulse extended by each subsequent push.
- With the command FIFO full, push 0x55 → dropped, cmd_ovf=1. Four snd_rd pops return 0x11, 0x22, 0x33, 0x44 in order, then cmd_count=0 and ctrl_sndbuf=0. Pulse ovf_clr → cmd_ovf=0.
- Sound pushes 0xA5 → host_int_b=0 at the next cycle. host_rd → host_dout=0xA5 (next cycle without FWFT, already present with FWFT). host_int_b returns to 1.
- Push 0x66 and pop in the same cycle on a full FIFO → count stays 4 and 0x66 becomes the tail. Same stimulus on an empty FIFO → count becomes 1 and dout does not change.
- Pop on an empty FIFO → no pointer move, no flag change.
- Assert snd_rst with 3 entries queued and an NMI active → counts 0, snd_nmi_b=1 and ctrl_sndbuf=0 at the next cycle, ovf flags preserved.
- Assert rst asynchronously between clock edges during traffic → all outputs at reset values before the next posedge.
